// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the single-channel PWM block.
package pwm_pkg;

  localparam int unsigned PWM_S_CNT_DEFAULT  = 200;
  localparam int unsigned PWM_DUTY_W_DEFAULT = 8;

  // Sample-counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm.sv
// Single-channel PWM: output high for the first on_time samples of each
// S_CNT-sample period, with on_time latched only at period start.
module pwm
  import pwm_pkg::*;
#(
  parameter int unsigned S_CNT  = PWM_S_CNT_DEFAULT,
  parameter int unsigned DUTY_W = PWM_DUTY_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DUTY_W-1:0] on_time,
  output logic              out,
  output logic              period_start
);

  localparam int unsigned CNT_W = cnt_width(S_CNT);
  // Wide enough to hold both cnt+1 and any duty value without truncation.
  localparam int unsigned CMP_W = ((CNT_W > DUTY_W) ? CNT_W : DUTY_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(S_CNT - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [DUTY_W-1:0] r_duty;
  logic              r_out;
  logic              r_period_start;

  logic              w_wrap;
  logic [CMP_W-1:0]  w_cnt_inc;
  logic              w_out_next;

  assign w_wrap     = (r_cnt == CNT_LAST);
  assign w_cnt_inc  = CMP_W'(r_cnt) + CMP_W'(1);
  assign w_out_next = (w_cnt_inc < CMP_W'(r_duty));

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= CNT_LAST;
      r_duty         <= '0;
      r_out          <= 1'b0;
      r_period_start <= 1'b0;
    end else if (!en) begin
      // Parking at the last sample makes the next enabled edge a fresh wrap.
      r_cnt          <= CNT_LAST;
      r_out          <= 1'b0;
      r_period_start <= 1'b0;
    end else if (w_wrap) begin
      r_cnt          <= '0;
      r_duty         <= on_time;
      r_out          <= (on_time != '0);
      r_period_start <= 1'b1;
    end else begin
      r_cnt          <= CNT_W'(w_cnt_inc);
      r_out          <= w_out_next;
      r_period_start <= 1'b0;
    end
  end

  assign out          = r_out;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_pwm.sv
// Scoreboard bench for pwm: a 200-sample channel and a 2-sample channel run
// side by side, with per-period high-time and length checks.
module tb_pwm;

  logic       clk;
  logic       rst_n;
  logic       en_a, en_b;
  logic [7:0] on_a;
  logic [1:0] on_b;
  logic       out_a, ps_a, out_b, ps_b;

  pwm #(.S_CNT(200), .DUTY_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .on_time(on_a),
    .out(out_a), .period_start(ps_a)
  );

  pwm #(.S_CNT(2), .DUTY_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .on_time(on_b),
    .out(out_b), .period_start(ps_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic out_a;
    logic ps_a;
    logic out_b;
    logic ps_b;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state for each channel
  int ma_cnt = 199, ma_duty = 0;
  int mb_cnt = 1,   mb_duty = 0;

  // Per-period statistics gathered from DUT outputs
  int hi_a = 0, len_a = 0, prev_hi_a = -1, prev_len_a = -1;
  int hi_b = 0, len_b = 0, prev_hi_b = -1, prev_len_b = -1;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int s, input logic rst, input logic en, input int on,
                       inout int cnt, inout int duty, output logic o, output logic p);
    if (!rst) begin
      cnt = s - 1; duty = 0; o = 1'b0; p = 1'b0;
    end else if (!en) begin
      cnt = s - 1; o = 1'b0; p = 1'b0;
    end else if (cnt == s - 1) begin
      cnt = 0; duty = on; o = (on > 0); p = 1'b1;
    end else begin
      cnt = cnt + 1; o = (cnt < duty); p = 1'b0;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      model(200, rst_n, en_a, int'(on_a), ma_cnt, ma_duty, e.out_a, e.ps_a);
      model(2,   rst_n, en_b, int'(on_b), mb_cnt, mb_duty, e.out_b, e.ps_b);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("out_a", int'(out_a), int'(e.out_a));
      check("ps_a",  int'(ps_a),  int'(e.ps_a));
      check("out_b", int'(out_b), int'(e.out_b));
      check("ps_b",  int'(ps_b),  int'(e.ps_b));
      if (ps_a) begin prev_hi_a = hi_a; prev_len_a = len_a; hi_a = 0; len_a = 0; end
      hi_a += int'(out_a); len_a++;
      if (ps_b) begin prev_hi_b = hi_b; prev_len_b = len_b; hi_b = 0; len_b = 0; end
      hi_b += int'(out_b); len_b++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b1;
    on_a  = 8'd10;
    on_b  = 2'd1;

    // Held in reset with enable and a non-zero duty: outputs stay low.
    step(3);
    check("rst_out_a", int'(out_a), 0);
    check("rst_ps_a",  int'(ps_a),  0);

    // Release away from the clock edge; first edge starts period 0.
    #2 rst_n = 1'b1;
    step(1);
    check("first_ps_a",  int'(ps_a),  1);
    check("first_out_a", int'(out_a), 1);

    // Steady duty of 10 over three periods.
    step(599);
    check("steady_hi_a",  prev_hi_a,  10);
    check("steady_len_a", prev_len_a, 200);
    check("small_hi_b",   prev_hi_b,  1);
    check("small_len_b",  prev_len_b, 2);

    // Mid-period increase at sample 5: current period keeps 10.
    while (ma_cnt != 5) step(1);
    on_a = 8'd50;
    step(195);
    check("upd50_cur_hi",  prev_hi_a, 10);
    step(200);
    check("upd50_next_hi", prev_hi_a, 50);

    // Mid-period decrease at sample 5 of a 10-high period.
    on_a = 8'd10;
    step(200);
    step(5);
    on_a = 8'd3;
    step(195);
    check("upd3_cur_hi",  prev_hi_a, 10);
    step(200);
    check("upd3_next_hi", prev_hi_a, 3);

    // Extremes: zero, exactly S_CNT, and saturated maximum.
    on_a = 8'd0;
    on_b = 2'd2;
    step(400);
    check("zero_hi_a",  prev_hi_a,  0);
    check("zero_len_a", prev_len_a, 200);
    check("full_hi_b",  prev_hi_b,  2);
    on_a = 8'd200;
    step(400);
    check("s_cnt_hi_a",  prev_hi_a,  200);
    check("s_cnt_len_a", prev_len_a, 200);
    on_a = 8'd255;
    step(400);
    check("max_hi_a",  prev_hi_a,  200);
    check("max_len_a", prev_len_a, 200);

    // Enable dropped at sample 4 of a 10-high period, then restored.
    on_a = 8'd10;
    on_b = 2'd1;
    step(200);
    while (ma_cnt != 4) step(1);
    check("pre_dis_out_a", int'(out_a), 1);
    en_a = 1'b0;
    step(1);
    check("dis_out_a", int'(out_a), 0);
    step(20);
    check("dis_hold_a", int'(out_a), 0);
    en_a = 1'b1;
    step(1);
    check("reen_ps_a",  int'(ps_a),  1);
    check("reen_out_a", int'(out_a), 1);
    step(200);
    check("reen_hi_a",  prev_hi_a,  10);
    check("reen_len_a", prev_len_a, 200);
    check("alt_hi_b",   prev_hi_b,  1);

    // Asynchronous reset in the high phase: outputs drop before any edge.
    while (ma_cnt != 3) step(1);
    check("pre_rst_out_a", int'(out_a), 1);
    rst_n = 1'b0;
    #1;
    check("async_out_a", int'(out_a), 0);
    check("async_ps_a",  int'(ps_a),  0);
    ma_cnt = 199; ma_duty = 0;
    mb_cnt = 1;   mb_duty = 0;
    step(2);
    #2 rst_n = 1'b1;
    step(1);
    check("rerun_ps_a",  int'(ps_a),  1);
    check("rerun_out_a", int'(out_a), 1);
    step(200);
    check("rerun_hi_a", prev_hi_a, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
